// File: rtl/dram_loader.sv
// Length-prefixed byte-stream loader for the matrix-multiply core's data RAM.
// Optional trailing-checksum support is enabled by defining LOADER_CHECKSUM_EN.
module dram_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    input  logic              i_clear,
    output logic              o_start,
    input  logic              i_core_busy,
    input  logic [ADDR_W-1:0] i_core_dram_addr,
    input  logic              i_core_dram_rd,
    input  logic              i_core_dram_wr,
    input  logic [7:0]        i_core_dram_out,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_read,
    output logic              o_dram_write,
    output logic [7:0]        o_dram_data,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [3:0] {
        ST_LEN_HI    = 4'd0,
        ST_LEN_LO    = 4'd1,
        ST_DATA      = 4'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK       = 4'd3,
`endif
        ST_START     = 4'd4,
        ST_WAIT_BUSY = 4'd5,
        ST_RUN       = 4'd6,
        ST_DONE      = 4'd7
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_ERR       = 4'd8
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              rx_ready_s;
    logic              accept_s;
    logic              core_owned_s;
    logic [15:0]       len_lo_s;

`ifdef LOADER_CHECKSUM_EN
    logic              err_q, err_d;
    logic [7:0]        chk_q, chk_d;

    // Running checksum: XOR of length bytes and payload
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // Stream handshake: the loader only listens while collecting header, payload or checksum
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_q)
            ST_LEN_HI: rx_ready_s = 1'b1;
            ST_LEN_LO: rx_ready_s = 1'b1;
            ST_DATA:   rx_ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:    rx_ready_s = 1'b1;
`endif
            default:   rx_ready_s = 1'b0;
        endcase
    end

    assign accept_s   = i_rx_valid & rx_ready_s;
    assign o_rx_ready = rx_ready_s;
    assign len_lo_s   = {len_q[15:8], i_rx_data};

    // Next-state and loader write-stage computation
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d   = {i_rx_data, len_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = i_rx_data;
`endif
                    state_d = ST_LEN_LO;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d = len_lo_s;
                    cnt_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_fold(chk_q, i_rx_data);
`endif
                    if (len_lo_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_START;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    // Address arithmetic wraps naturally at 2^ADDR_W
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + ADDR_W'(cnt_q);
                    wr_data_d = i_rx_data;
                    cnt_d     = cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = chk_fold(chk_q, i_rx_data);
`endif
                    if (cnt_q == (len_q - 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_START;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    if (i_rx_data == chk_q) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
`endif
            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_core_busy) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_RUN: begin
                if (!i_core_busy) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_clear) begin
                    state_d = ST_LEN_HI;
                    len_d   = 16'd0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_ERR: begin
                if (i_clear) begin
                    state_d = ST_LEN_HI;
                    len_d   = 16'd0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_LEN_HI;
            end
        endcase
    end

    // The start strobe is taken from the START state of the previous cycle, so it always
    // lands one cycle after the final loader write has been issued.
    assign start_d = (state_q == ST_START);
    assign done_d  = (state_d == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
    assign err_d   = (state_d == ST_ERR);
`endif

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_LEN_HI;
            len_q     <= 16'd0;
            cnt_q     <= 16'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= 8'd0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
            chk_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            done_q    <= done_d;
`ifdef LOADER_CHECKSUM_EN
            err_q     <= err_d;
            chk_q     <= chk_d;
`endif
        end
    end

    assign core_owned_s = (state_q == ST_WAIT_BUSY) || (state_q == ST_RUN) ||
                          (state_q == ST_DONE);

    // DRAM port ownership: core drives the port straight through while it runs
    always_comb begin
        if (core_owned_s) begin
            o_dram_addr  = i_core_dram_addr;
            o_dram_read  = i_core_dram_rd;
            o_dram_write = i_core_dram_wr;
            o_dram_data  = i_core_dram_out;
        end else begin
            o_dram_addr  = wr_addr_q;
            o_dram_read  = 1'b0;
            o_dram_write = wr_en_q;
            o_dram_data  = wr_data_q;
        end
    end

    assign o_start = start_q;
    assign o_done  = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign o_error = err_q;
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_dram_loader.sv
// Directed testbench for dram_loader: cycle table plus hand-written multi-cycle sequences.
module tb_dram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        clear;
    logic        core_busy;
    logic [15:0] core_addr;
    logic        core_rd;
    logic        core_wr;
    logic [7:0]  core_out;

    logic        a_ready, a_start, a_rd, a_wr, a_done, a_err;
    logic [15:0] a_addr;
    logic [7:0]  a_data;
    logic        b_ready, b_start, b_rd, b_wr, b_done, b_err;
    logic [15:0] b_addr;
    logic [7:0]  b_data;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    logic [23:0] wq_a[$];
    logic [23:0] wq_b[$];

    always #5 clk = ~clk;

    dram_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(a_ready), .i_clear(clear), .o_start(a_start), .i_core_busy(core_busy),
        .i_core_dram_addr(core_addr), .i_core_dram_rd(core_rd), .i_core_dram_wr(core_wr),
        .i_core_dram_out(core_out), .o_dram_addr(a_addr), .o_dram_read(a_rd),
        .o_dram_write(a_wr), .o_dram_data(a_data), .o_done(a_done), .o_error(a_err));

    dram_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFE)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(b_ready), .i_clear(clear), .o_start(b_start), .i_core_busy(core_busy),
        .i_core_dram_addr(core_addr), .i_core_dram_rd(core_rd), .i_core_dram_wr(core_wr),
        .i_core_dram_out(core_out), .o_dram_addr(b_addr), .o_dram_read(b_rd),
        .o_dram_write(b_wr), .o_dram_data(b_data), .o_done(b_done), .o_error(b_err));

    // Write/start monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (a_wr) wq_a.push_back({a_addr, a_data});
        if (b_wr) wq_b.push_back({b_addr, b_data});
        if (a_start) start_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        busy;
        logic        clr;
        logic        cwr;
        logic        crd;
        logic [15:0] caddr;
        logic [7:0]  cout;
        logic        e_ready;
        logic        e_wr;
        logic        e_rd;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_start;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic bz, logic cl, logic cw, logic cr,
                                logic [15:0] ca, logic [7:0] co, logic er, logic ew, logic erd,
                                logic [15:0] ea, logic [7:0] ed, logic es, logic edn);
        vec_t r;
        r.valid = v;   r.data = d;    r.busy = bz;  r.clr = cl;
        r.cwr = cw;    r.crd = cr;    r.caddr = ca; r.cout = co;
        r.e_ready = er; r.e_wr = ew;  r.e_rd = erd; r.e_addr = ea;
        r.e_data = ed; r.e_start = es; r.e_done = edn;
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!a_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!a_ready) check("send_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Expects a start strobe, then plays a short core busy window and clears DONE
    task automatic run_core(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_start) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_start_seen"}, 32'(ok), 32'd1);
        core_busy = 1'b1;
        idle(2);
        core_busy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (a_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(ok), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check({name, "_done_cleared"}, 32'(a_done), 32'd0);
        check({name, "_ready_after_clear"}, 32'(a_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear = 1'b0; core_busy = 1'b0;
        core_addr = 16'h0000; core_rd = 1'b0; core_wr = 1'b0; core_out = 8'h00;
        #12;
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_write", 32'(a_wr), 32'd0);
        check("rst_read", 32'(a_rd), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_start", 32'(a_start), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_error", 32'(a_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stream 00 03 11 22 33, core run with a mirrored write and read, then clear
        tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h11, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0001, 8'h22, 1'b0, 1'b0));
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0002, 8'h33, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
`else
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0002, 8'h33, 1'b0, 1'b0));
`endif
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h5A, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h5A, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0456, 8'hC7, 1'b0, 1'b0, 1'b1, 16'h0456, 8'hC7, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rx_valid = tbl[i].valid; rx_data = tbl[i].data; core_busy = tbl[i].busy;
            clear = tbl[i].clr; core_wr = tbl[i].cwr; core_rd = tbl[i].crd;
            core_addr = tbl[i].caddr; core_out = tbl[i].cout;
            #1;
            check($sformatf("v%0d_ready", i), 32'(a_ready), 32'(tbl[i].e_ready));
            check($sformatf("v%0d_write", i), 32'(a_wr), 32'(tbl[i].e_wr));
            check($sformatf("v%0d_read", i), 32'(a_rd), 32'(tbl[i].e_rd));
            check($sformatf("v%0d_start", i), 32'(a_start), 32'(tbl[i].e_start));
            check($sformatf("v%0d_done", i), 32'(a_done), 32'(tbl[i].e_done));
            if (tbl[i].e_wr || tbl[i].e_rd) begin
                check($sformatf("v%0d_addr", i), 32'(a_addr), 32'(tbl[i].e_addr));
                check($sformatf("v%0d_data", i), 32'(a_data), 32'(tbl[i].e_data));
            end
        end
        rx_valid = 1'b0; core_busy = 1'b0; clear = 1'b0; core_wr = 1'b0; core_rd = 1'b0;
        core_addr = 16'h0000; core_out = 8'h00;

        // Zero-length stream: no writes, single start pulse, done then clear
        idle(1);
        wq_a.delete(); start_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        run_core("len0");
        check("len0_no_writes", 32'(wq_a.size()), 32'd0);
        check("len0_one_start", 32'(start_cnt), 32'd1);

        // Gapped stream, BASE_ADDR=FFFE wraps to 0000
        wq_a.delete(); wq_b.delete();
        send_byte(8'h00); idle(2);
        send_byte(8'h03); idle(1);
        send_byte(8'hA1); idle(3);
        send_byte(8'hB2);
        send_byte(8'hC3);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hD3);
`endif
        run_core("wrap");
        check("wrap_b_count", 32'(wq_b.size()), 32'd3);
        check("wrap_b0", 32'(wq_b.size() > 0 ? wq_b[0] : 24'hxxxxxx), 32'h00FFFEA1);
        check("wrap_b1", 32'(wq_b.size() > 1 ? wq_b[1] : 24'hxxxxxx), 32'h00FFFFB2);
        check("wrap_b2", 32'(wq_b.size() > 2 ? wq_b[2] : 24'hxxxxxx), 32'h000000C3);
        check("wrap_a2", 32'(wq_a.size() > 2 ? wq_a[2] : 24'hxxxxxx), 32'h000002C3);

        // Asynchronous reset while a payload write is in flight, then a fresh stream
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        check("mid_pre_write", 32'(a_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_write", 32'(a_wr), 32'd0);
        check("mid_rst_addr", 32'(a_addr), 32'd0);
        check("mid_rst_data", 32'(a_data), 32'd0);
        check("mid_rst_start", 32'(a_start), 32'd0);
        check("mid_rst_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wq_a.delete();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAB);
`endif
        run_core("reload");
        check("reload_count", 32'(wq_a.size()), 32'd1);
        check("reload_w0", 32'(wq_a.size() > 0 ? wq_a[0] : 24'hxxxxxx), 32'h000000AA);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match then mismatch
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h01);
        run_core("chk_ok");
        start_cnt = 0;
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'hFF);
        idle(4);
        #1;
        check("chk_bad_error", 32'(a_err), 32'd1);
        check("chk_bad_no_start", 32'(start_cnt), 32'd0);
        check("chk_bad_ready", 32'(a_ready), 32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("chk_bad_cleared", 32'(a_err), 32'd0);
        check("chk_bad_ready_after", 32'(a_ready), 32'd1);
`else
        check("no_chk_error_low", 32'(a_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
